pxs_cursor_gen: RTL

//  Parametrised text-console cursor overlay on the 26-bit RGB pixel stream.

---
 rtl/pxs_cursor_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pxs_cursor_gen.sv
// Text-console cursor overlay on the 26-bit RGB pixel stream, two-stage pipeline.
// Optional build macro PXS_CURSOR_COLOR_EN: hit pixels take a latched cursor colour instead of inverted RGB.
module pxs_cursor_gen #(
  parameter int GW_LOG2      = 3,
  parameter int GH_LOG2      = 4,
  parameter int POS_W        = 7,
  parameter int UL_ROWS      = 2,
  parameter int BAR_COLS     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             px_clk,
  input  logic             reset,
  input  logic [25:0]      RGBStr_i,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic [3:0]       tcursor,
  input  logic [2:0]       cursor_rgb,
  output logic [25:0]      RGBStr_o,
  output logic             cursor_hit
);

  typedef enum logic [1:0] {
    SHAPE_OFF       = 2'd0,
    SHAPE_BLOCK     = 2'd1,
    SHAPE_UNDERLINE = 2'd2,
    SHAPE_BAR       = 2'd3
  } shape_e;

  localparam int          CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [31:0] UL_START = 32'((1 << GH_LOG2) - UL_ROWS);
  localparam logic [31:0] BAR_LIM  = 32'(BAR_COLS);

  // Frame-synchronous shadow state
  logic             vs_prev_q,  vs_prev_d;
  logic [POS_W-1:0] pos_x_q,    pos_x_d;
  logic [POS_W-1:0] pos_y_q,    pos_y_d;
  shape_e           shape_q,    shape_d;
  logic             blink_en_q, blink_en_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q,    phase_d;

  // Pipeline
  logic [25:0]      s1_stream_q,  s1_stream_d;
  logic             s1_hit_q,     s1_hit_d;
  logic [25:0]      out_stream_q, out_stream_d;
  logic             out_hit_q,    out_hit_d;

`ifdef PXS_CURSOR_COLOR_EN
  logic [2:0]       color_q,    color_d;
  logic [2:0]       s1_color_q, s1_color_d;
`else
  logic             unused_cursor_rgb;
  assign unused_cursor_rgb = ^cursor_rgb;
`endif

  logic unused_tcursor_rsvd;
  assign unused_tcursor_rsvd = tcursor[3];

  logic frame_tick;
  assign frame_tick = RGBStr_i[1] & ~vs_prev_q;

  always_comb begin : shadow_comb
    // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
    vs_prev_d   = RGBStr_i[1];
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    shape_d     = shape_q;
    blink_en_d  = blink_en_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
`ifdef PXS_CURSOR_COLOR_EN
    color_d     = color_q;
`endif
    if (frame_tick) begin
      pos_x_d    = pos_x;
      pos_y_d    = pos_y;
      shape_d    = shape_e'(tcursor[1:0]);
      blink_en_d = tcursor[2];
`ifdef PXS_CURSOR_COLOR_EN
      color_d    = cursor_rgb;
`endif
      if (blink_cnt_q == CNT_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: hit uses the shadow values as they stand before any same-cycle tick.
  logic [9:0]         xc, yc;
  logic [GW_LOG2-1:0] cx;
  logic [GH_LOG2-1:0] cy;
  logic               col_match, row_match, in_shape, visible;

  always_comb begin : hit_comb
    xc        = RGBStr_i[22:13];
    yc        = RGBStr_i[12:3];
    cx        = xc[GW_LOG2-1:0];
    cy        = yc[GH_LOG2-1:0];
    col_match = (32'(xc >> GW_LOG2) == 32'(pos_x_q));
    row_match = (32'(yc >> GH_LOG2) == 32'(pos_y_q));
    in_shape  = 1'b0;
    unique case (shape_q)
      SHAPE_OFF:       in_shape = 1'b0;
      SHAPE_BLOCK:     in_shape = 1'b1;
      SHAPE_UNDERLINE: in_shape = (32'(cy) >= UL_START);
      SHAPE_BAR:       in_shape = (32'(cx) < BAR_LIM);
      default:         in_shape = 1'b0;
    endcase
    visible     = phase_q | ~blink_en_q;
    s1_stream_d = RGBStr_i;
    s1_hit_d    = RGBStr_i[0] & col_match & row_match & in_shape & visible;
`ifdef PXS_CURSOR_COLOR_EN
    s1_color_d  = color_q;
`endif
  end

  // Stage 2: recolour the hit pixel, everything else passes through.
  always_comb begin : colour_comb
    out_stream_d = s1_stream_q;
    out_hit_d    = s1_hit_q;
    if (s1_hit_q) begin
`ifdef PXS_CURSOR_COLOR_EN
      out_stream_d[25:23] = s1_color_q;
`else
      out_stream_d[25:23] = ~s1_stream_q[25:23];
`endif
    end
  end

  always_ff @(posedge px_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      vs_prev_q    <= 1'b0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      shape_q      <= SHAPE_OFF;
      blink_en_q   <= 1'b0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      s1_stream_q  <= '0;
      s1_hit_q     <= 1'b0;
      out_stream_q <= '0;
      out_hit_q    <= 1'b0;
`ifdef PXS_CURSOR_COLOR_EN
      color_q      <= '0;
      s1_color_q   <= '0;
`endif
    end else begin
      vs_prev_q    <= vs_prev_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      shape_q      <= shape_d;
      blink_en_q   <= blink_en_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      s1_stream_q  <= s1_stream_d;
      s1_hit_q     <= s1_hit_d;
      out_stream_q <= out_stream_d;
      out_hit_q    <= out_hit_d;
`ifdef PXS_CURSOR_COLOR_EN
      color_q      <= color_d;
      s1_color_q   <= s1_color_d;
`endif
    end
  end

  assign RGBStr_o   = out_stream_q;
  assign cursor_hit = out_hit_q;

endmodule
